scan_sequencer: RTL

//  Runs the Knight Rider light bar: a single lit LED sweeps up and down the bar, pausing at each end.

---
 rtl/knight_rider_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 50 +++++
 rtl/scan_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/knight_rider_pkg.sv
// Shared types and width helpers for the Knight Rider light bar sequencer.
package knight_rider_pkg;

   typedef enum logic [1:0] {
      SCAN_UP,
      HOLD_TOP,
      SCAN_DOWN,
      HOLD_BOTTOM
   } scan_state_t;

   // Position index width; never narrower than one bit.
   function automatic int pos_w(input int num_leds);
      return (num_leds > 1) ? $clog2(num_leds) : 1;
   endfunction

   // Hold counter width; HOLD_STEPS=0 still gets a (never used) one-bit counter.
   function automatic int hold_w(input int hold_steps);
      return (hold_steps > 0) ? (($clog2(hold_steps + 1) > 0) ? $clog2(hold_steps + 1) : 1) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable step prescaler with a shadowed period that is swapped in on a tick.
module tick_prescaler #(
   parameter int CNT_W        = 24,
   parameter int RESET_PERIOD = 12_500_000
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] period_in,
   input  logic             period_load,
   output logic             tick,
   output logic             period_pending
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] period_reg;
   logic [CNT_W-1:0] shadow_reg;
   logic             pending_reg;
   logic [CNT_W-1:0] last_count;

   // A zero period behaves as a period of one: tick on every enabled cycle.
   assign last_count     = (period_reg == '0) ? '0 : period_reg - CNT_W'(1);
   assign tick           = enable && !reset && (cnt_reg == last_count);
   assign period_pending = pending_reg;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_reg     <= '0;
         period_reg  <= CNT_W'(RESET_PERIOD);
         shadow_reg  <= '0;
         pending_reg <= 1'b0;
      end else begin
         if (tick)
            cnt_reg <= '0;
         else if (enable)
            cnt_reg <= cnt_reg + CNT_W'(1);

         if (tick && pending_reg) begin
            period_reg  <= shadow_reg;
            pending_reg <= 1'b0;
         end
         // Placed last so a load coincident with a tick stays pending for the next one.
         if (period_load) begin
            shadow_reg  <= period_in;
            pending_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_sequencer.sv
// Knight Rider light bar: one lit LED sweeps up and down, holding at each end.
module scan_sequencer
   import knight_rider_pkg::*;
#(
   parameter int NUM_LEDS     = 8,
   parameter int CNT_W        = 24,
   parameter int RESET_PERIOD = 12_500_000,
   parameter int HOLD_STEPS   = 2
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                enable,
   input  logic [CNT_W-1:0]    period_in,
   input  logic                period_load,
   output logic                period_pending,
   output logic [NUM_LEDS-1:0] leds,
   output logic                step_tick,
   output logic                at_end
);

   localparam int                POS_W     = pos_w(NUM_LEDS);
   localparam int                HOLD_W    = hold_w(HOLD_STEPS);
   localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(NUM_LEDS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

   scan_state_t         state_reg, state_next;
   logic [POS_W-1:0]    pos_reg, pos_next;
   logic [HOLD_W-1:0]   hold_reg, hold_next;
   logic [NUM_LEDS-1:0] leds_reg, leds_next;
   logic                tick;

   tick_prescaler #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
   ) u_prescaler (
      .clk_in         (clk_in),
      .reset          (reset),
      .enable         (enable),
      .period_in      (period_in),
      .period_load    (period_load),
      .tick           (tick),
      .period_pending (period_pending)
   );

   always_comb begin
      state_next = state_reg;
      pos_next   = pos_reg;
      hold_next  = hold_reg;
      case (state_reg)
         SCAN_UP: begin
            pos_next = pos_reg + POS_W'(1);
            if (pos_next == POS_TOP) begin
               state_next = (HOLD_STEPS == 0) ? SCAN_DOWN : HOLD_TOP;
               hold_next  = '0;
            end
         end
         HOLD_TOP: begin
            hold_next = hold_reg + HOLD_W'(1);
            if (hold_reg == HOLD_LAST) begin
               state_next = SCAN_DOWN;
               hold_next  = '0;
            end
         end
         SCAN_DOWN: begin
            pos_next = pos_reg - POS_W'(1);
            if (pos_next == '0) begin
               state_next = (HOLD_STEPS == 0) ? SCAN_UP : HOLD_BOTTOM;
               hold_next  = '0;
            end
         end
         HOLD_BOTTOM: begin
            hold_next = hold_reg + HOLD_W'(1);
            if (hold_reg == HOLD_LAST) begin
               state_next = SCAN_UP;
               hold_next  = '0;
            end
         end
         default: state_next = SCAN_UP;
      endcase
   end

   // One-hot decode of the next position.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
         assign leds_next[gi] = (pos_next == POS_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_reg <= SCAN_UP;
         pos_reg   <= '0;
         hold_reg  <= '0;
         leds_reg  <= NUM_LEDS'(1);
      end else if (tick) begin
         state_reg <= state_next;
         pos_reg   <= pos_next;
         hold_reg  <= hold_next;
         leds_reg  <= leds_next;
      end
   end

   assign leds      = leds_reg;
   assign step_tick = tick;
   assign at_end    = (pos_reg == '0) || (pos_reg == POS_TOP);

endmodule
